// File: rtl/dfa_pkg.sv
// Shared definitions for rule_scheduler: FSM state encoding, rule-table
// field codes, the position of the enable bit inside a control word, and
// the default table geometry.
package dfa_pkg;

  localparam int DEF_NRULES = 4;
  localparam int DEF_DW     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Low two bits of CFG_ADDR select the field of the addressed rule.
  localparam logic [1:0] FLD_PATTERN = 2'd0;
  localparam logic [1:0] FLD_MASK    = 2'd1;
  localparam logic [1:0] FLD_CTRL    = 2'd2;
  localparam logic [1:0] FLD_RSVD    = 2'd3;

  // Words are numbered [0:DW-1] with bit 0 the MSB, so the enable flag
  // (index DW-1) is the numerically least-significant bit.
  function automatic int ctrl_en_bit(int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/rule_cmp.sv
// Single-rule comparator (purely combinational).
//   snap_i    : captured data word
//   pattern_i : rule pattern
//   mask_i    : rule mask, 1 = bit participates in the compare
//   enable_i  : rule enable
//   hit_o     : enabled and all masked bits equal
module rule_cmp #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] snap_i,
  input  logic [DW-1:0] pattern_i,
  input  logic [DW-1:0] mask_i,
  input  logic          enable_i,
  output logic          hit_o
);

  assign hit_o = enable_i && (((snap_i ^ pattern_i) & mask_i) == '0);

endmodule

// File: rtl/rule_scheduler.sv
// Sequential rule matcher. A START in IDLE snapshots DATA and walks the
// rule table one entry per clock (lowest index first); the first enabled
// rule whose masked bits equal the snapshot wins. One REPORT cycle then
// strobes DONE with RESULT/MATCH_ID, which hold until the next DONE.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CFG_WE/ADDR/WDATA   rule table write: ADDR = {rule, field}
//   DATA, START         word to classify and its request strobe
//   BUSY, DONE          scan in progress / one-cycle result strobe
//   RESULT, MATCH_ID    hit flag and winning rule index
//   CFG_ERR             one-cycle pulse for a write attempted while busy
//   CNT_SEL, HIT_CNT    per-rule hit counter readout (only when
//                       RULE_SCHEDULER_HITCNT_EN is defined)
module rule_scheduler
  import dfa_pkg::*;
#(
  parameter int NRULES = DEF_NRULES,
  parameter int DW     = DEF_DW
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CFG_WE,
  input  logic [$clog2(NRULES)+1:0]    CFG_ADDR,
  input  logic [0:DW-1]                CFG_WDATA,
  input  logic [0:DW-1]                DATA,
  input  logic                         START,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         RESULT,
  output logic [$clog2(NRULES)-1:0]    MATCH_ID,
  output logic                         CFG_ERR
`ifdef RULE_SCHEDULER_HITCNT_EN
  ,
  input  logic [$clog2(NRULES)-1:0]    CNT_SEL,
  output logic [15:0]                  HIT_CNT
`endif
);

  localparam int IW     = $clog2(NRULES);
  localparam int EN_POS = ctrl_en_bit(DW);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   snap_q;
  logic            result_q, result_d;
  logic [IW-1:0]   match_id_q, match_id_d;
  logic            cfg_err_q;

  logic [DW-1:0]     pat_q [NRULES];
  logic [DW-1:0]     msk_q [NRULES];
  logic [NRULES-1:0] en_q;

  logic          busy;
  logic          wr_ok;
  logic [IW-1:0] wr_rule;
  logic [1:0]    wr_fld;
  logic          hit;

  assign busy    = (state_q != ST_IDLE);
  assign wr_ok   = CFG_WE && !busy;
  assign wr_rule = CFG_ADDR[IW+1:2];
  assign wr_fld  = CFG_ADDR[1:0];

  // ---------------------------------------------------------------- table
  // Writes land at the START edge too, so a scan launched in the same
  // cycle already sees the new entry when it reaches it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NRULES; r++) begin
        pat_q[r] <= '0;
        msk_q[r] <= '1;
      end
      en_q <= '0;
    end else if (wr_ok) begin
      case (wr_fld)
        FLD_PATTERN: pat_q[wr_rule] <= CFG_WDATA;
        FLD_MASK:    msk_q[wr_rule] <= CFG_WDATA;
        FLD_CTRL:    en_q[wr_rule]  <= CFG_WDATA[EN_POS];
        default:     ;
      endcase
    end
  end

  // --------------------------------------------------------- comparator
  rule_cmp #(.DW(DW)) u_cmp (
    .snap_i    (snap_q),
    .pattern_i (pat_q[idx_q]),
    .mask_i    (msk_q[idx_q]),
    .enable_i  (en_q[idx_q]),
    .hit_o     (hit)
  );

  // ------------------------------------------------------------------ fsm
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    result_d   = result_q;
    match_id_d = match_id_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          state_d    = ST_REPORT;
          result_d   = 1'b1;
          match_id_d = idx_q;
        end else if (idx_q == IW'(NRULES - 1)) begin
          state_d    = ST_REPORT;
          result_d   = 1'b0;
          match_id_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      result_q   <= 1'b0;
      match_id_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      match_id_q <= match_id_d;
      cfg_err_q  <= CFG_WE && busy;
      if (state_q == ST_IDLE && START) snap_q <= DATA;
    end
  end

  assign BUSY     = busy;
  assign DONE     = (state_q == ST_REPORT);
  assign RESULT   = result_q;
  assign MATCH_ID = match_id_q;
  assign CFG_ERR  = cfg_err_q;

`ifdef RULE_SCHEDULER_HITCNT_EN
  // ------------------------------------------------------- hit counters
  // Counts are taken in the REPORT cycle from the registered result. A
  // control-field write can never coincide with it (writes are dropped
  // while busy), so clear and increment never race.
  logic [NRULES-1:0][15:0] cnt_q;

  for (genvar r = 0; r < NRULES; r++) begin : g_cnt
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q[r] <= '0;
      end else if (wr_ok && wr_fld == FLD_CTRL && wr_rule == IW'(r)) begin
        cnt_q[r] <= '0;
      end else if (state_q == ST_REPORT && result_q &&
                   match_id_q == IW'(r) && cnt_q[r] != 16'hFFFF) begin
        cnt_q[r] <= cnt_q[r] + 16'd1;
      end
    end
  end

  assign HIT_CNT = cnt_q[CNT_SEL];
`endif

endmodule

// File: doc/rule_scheduler.md
RULE_SCHEDULER -- requirements
Module: rule_scheduler

Interface
REQ-001 SHALL have parameter NRULES, default 4, meaning number of match rules (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 32, meaning width of DATA, pattern and mask words.
REQ-003 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port CFG_WE  input  1  rule-table write strobe.
REQ-006 SHALL have port CFG_ADDR  input  log2(NRULES)+2  rule index (upper bits) and field (low 2 bits): 0 pattern, 1 mask, 2 control (bit DW-1 = enable), 3 reserved.
REQ-007 SHALL have port CFG_WDATA  input  DW  write data, indexed [0:DW-1], bit 0 MSB.
REQ-008 SHALL have port DATA  input  DW  word to classify, indexed [0:DW-1].
REQ-009 SHALL have port START  input  1  single-cycle request to classify DATA.
REQ-010 SHALL have port BUSY  output  1  scan in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle result-valid strobe.
REQ-012 SHALL have port RESULT  output  1  1 = some enabled rule matched; valid while DONE.
REQ-013 SHALL have port MATCH_ID  output  log2(NRULES)  index of matching rule; valid while DONE and RESULT.
REQ-014 SHALL have port CFG_ERR  output  1  one-cycle pulse: write rejected.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> REPORT -> IDLE.
REQ-016 IDLE: START=1 at edge E0 SHALL snapshot DATA, set idx=0, BUSY=1, enter SCAN.
REQ-017 SCAN: each edge SHALL evaluate exactly one rule idx: hit = enable & (((snap ^ pattern) & mask) == 0).
REQ-018 On hit SHALL enter REPORT with RESULT=1, MATCH_ID=idx (lowest index wins).
REQ-019 On miss at idx=NRULES-1 SHALL enter REPORT with RESULT=0, MATCH_ID=0; otherwise idx+1.
REQ-020 Disabled rules SHALL still consume one SCAN cycle (deterministic latency).
REQ-021 Latency: DONE high after edge E(i+1) for hit on rule i; after edge E(NRULES) for no hit.
REQ-022 REPORT SHALL last exactly one cycle: DONE=1, BUSY=1; then IDLE with BUSY=0, DONE=0.
REQ-023 RESULT and MATCH_ID SHALL hold their values until the next DONE.
REQ-024 START while BUSY=1 SHALL be ignored; next START accepted in IDLE only (earliest the cycle after REPORT).
REQ-025 CFG_WE in IDLE SHALL write the addressed field at that edge; field 3 writes ignored without error.
REQ-026 CFG_WE while BUSY=1 SHALL be dropped and pulse CFG_ERR one cycle.
REQ-027 CFG_WE and START in the same IDLE cycle: write SHALL take effect, then the scan SHALL use the updated table.
REQ-028 mask=0 on an enabled rule SHALL match any DATA.

Reset
REQ-029 RST=1 SHALL asynchronously force IDLE, idx=0, BUSY=0, DONE=0, RESULT=0, MATCH_ID=0, CFG_ERR=0.
REQ-030 RST SHALL clear every rule: pattern=0, mask=all ones, enable=0.
REQ-031 RST asserted mid-SCAN SHALL abort the scan with no DONE pulse.

Configuration
REQ-032 Macro RULE_SCHEDULER_HITCNT_EN defined: SHALL add input CNT_SEL (log2(NRULES)) and output HIT_CNT (16), a per-rule saturating counter (stops at 0xFFFF) incremented on each DONE with RESULT=1 for that rule, cleared by RST or a write to that rule's control field; HIT_CNT shows counter CNT_SEL combinationally.
REQ-033 Macro undefined: SHALL have no CNT_SEL/HIT_CNT ports and no counter logic; all other behaviour identical.

Structure
REQ-034 Package dfa_pkg SHALL hold the FSM state enum, field codes (FLD_PATTERN, FLD_MASK, FLD_CTRL), enable bit position and default NRULES/DW.
REQ-035 SHALL instantiate one combinational sub-module rule_cmp (snap, pattern, mask, enable -> hit); the rule table stays in rule_scheduler.

Verification
REQ-036 After reset, START with DATA=0x00000006 -> DONE after 4 cycles (NRULES=4), RESULT=0, no CFG_ERR.
REQ-037 Rule 2 pattern=0x00000006, mask=0xFFFFFFFF, enabled; START with DATA=0x00000006 -> DONE after 3 cycles, RESULT=1, MATCH_ID=2.
REQ-038 Rules 1 and 3 both enabled with mask=0; START -> DONE after 2 cycles, MATCH_ID=1.
REQ-039 START, then CFG_WE and a second START 1 cycle later -> CFG_ERR pulses once, table unchanged, exactly one DONE.
REQ-040 RST pulsed 2 cycles after START -> no DONE, BUSY=0, all rules disabled; next START -> RESULT=0.
REQ-041 With RULE_SCHEDULER_HITCNT_EN: 65537 hits on rule 0 -> HIT_CNT(CNT_SEL=0)=0xFFFF; write rule 0 control -> 0.
